// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: frame data-bit and parity
// encodings, receiver error-bus bit indices, default buffer geometry and the
// width of a buffered entry (data plus two error tags).
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Default receive buffer geometry.
  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_DATA_W = 9;

  // Bit positions on the receiver error bus rx_error[2:0].
  localparam int FRAME_ERR   = 2;
  localparam int PARITY_ERR  = 1;
  localparam int OVERRUN_ERR = 0;

  // Frame data-bit count encoding.
  typedef enum logic [1:0] {
    DBITS_5 = 2'd0,
    DBITS_6 = 2'd1,
    DBITS_7 = 2'd2,
    DBITS_8 = 2'd3
  } data_bits_e;

  // Frame parity mode encoding.
  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } parity_e;

  // A buffered entry is {frame_err, parity_err, data}.
  function automatic int entry_w(input int data_w);
    return data_w + 2;
  endfunction

  localparam int DEFAULT_ENTRY_W = DEFAULT_DATA_W + 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Generic register-array FIFO with first-word-fall-through read. The usable
// capacity is set at run time through 'cap' (1..DEPTH); pointers wrap at cap,
// so cap=1 keeps all traffic in slot 0. The head entry is held in a register
// that is loaded with the next-cycle head, so rd_data is a flop output and
// keeps its last value while the FIFO is empty.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear of pointers and level (head data retained)
//   cap          capacity in entries, 1..DEPTH
//   wr_en        write request; accepted when not full or when popping
//   wr_data      write data
//   rd_en        pop request; ignored when empty
//   rd_data      head entry
//   empty/full   status for the current level
//   level        current entry count
//   level_next   entry count after this clock edge
//   wr_ok/rd_ok  write/pop actually performed this cycle
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 11,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [AW:0]      cap,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level,
  output logic [AW:0]      level_next,
  output logic             wr_ok,
  output logic             rd_ok
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;

  // Advance a pointer, wrapping at the run-time capacity.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr,
                                            input logic [AW:0]   lim);
    logic [AW:0] nxt;
    nxt = {1'b0, ptr} + {{AW{1'b0}}, 1'b1};
    if (nxt >= lim) begin
      return {AW{1'b0}};
    end else begin
      return nxt[AW-1:0];
    end
  endfunction

  assign empty = (level_q == {(AW+1){1'b0}});
  assign full  = (level_q == cap);
  assign rd_ok = rd_en & ~empty & ~clr;
  // A full FIFO still takes a write when the same cycle pops.
  assign wr_ok = wr_en & ~clr & (~full | rd_ok);

  // Next-state pointers, level and head register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (clr) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {(AW+1){1'b0}};
    end else begin
      if (wr_ok) begin
        wr_ptr_d = ptr_inc(wr_ptr_q, cap);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q, cap);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      level_d = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      // The slot being written this cycle can only be the new head when the
      // FIFO is left with exactly that one entry, so bypass the array then.
      if (level_d == {(AW+1){1'b0}}) begin
        head_d = head_q;
      end else if (wr_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wr_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Pointer, level and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {(AW+1){1'b0}};
      head_q   <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data    = head_q;
  assign level      = level_q;
  assign level_next = level_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART receiver. Each rx_done pulse captures
// {frame_err, parity_err, data}; the host sees the oldest entry first-word-
// fall-through. fifo_en selects a DEPTH-entry FIFO or a single holding
// register; toggling it, or asserting flush, discards all contents. A frame
// arriving with no room is dropped and sets the sticky overrun flag.
// Optional macro UART_RX_TIMEOUT_EN adds a receive-timeout interrupt.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   fifo_en                 1: DEPTH-entry FIFO, 0: single holding register
//   flush                   synchronous clear of contents and overrun flag
//   rx_done/rx_success      receiver frame strobe / low on parity error
//   rx_data, rx_error       receiver data and error bus ([2] frame error)
//   fifo_full, rx_data_read back to receiver: no room / holding reg consumed
//   rd_en                   host pop (ignored when empty)
//   rd_data, rd_err         head data and tags {frame_err, parity_err}
//   empty, level            status and entry count
//   rx_thresh, irq_level    level interrupt threshold (0 acts as 1) and irq
//   ovr_flag, ovr_clr       sticky overrun flag and its clear
//   timeout_cycles,         (UART_RX_TIMEOUT_EN only) idle-cycle limit and
//   irq_timeout              timeout interrupt
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_en,
  input  logic              flush,
  input  logic              rx_done,
  input  logic              rx_success,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [2:0]        rx_error,
  output logic              fifo_full,
  output logic              rx_data_read,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_err,
  output logic              empty,
  output logic [AW:0]       level,
  input  logic [AW:0]       rx_thresh,
  output logic              irq_level,
`ifdef UART_RX_TIMEOUT_EN
  input  logic [23:0]       timeout_cycles,
  output logic              irq_timeout,
`endif
  output logic              ovr_flag,
  input  logic              ovr_clr
);

  localparam int EW = entry_w(DATA_W);

  logic          fifo_en_q;
  logic          mode_chg_s, clr_s, push_s, pop_s;
  logic          wr_ok_s, rd_ok_s, full_s, empty_s, overrun_s;
  logic [AW:0]   cap_s, level_s, level_next_s, thresh_s;
  logic [EW-1:0] wr_entry_s, rd_entry_s;
  logic          ovr_q, ovr_d;
  logic          irq_level_q, irq_level_d;
  logic          unused_err_s;

  // Overrun and parity bits of the error bus are not buffered.
  assign unused_err_s = ^{rx_error[PARITY_ERR], rx_error[OVERRUN_ERR]};

  assign mode_chg_s = fifo_en ^ fifo_en_q;
  assign clr_s      = flush | mode_chg_s;
  // Frames arriving during a clear are discarded and never count as overrun.
  assign push_s     = rx_done & ~clr_s;
  assign pop_s      = rd_en & ~clr_s;
  assign cap_s      = fifo_en ? (AW+1)'(DEPTH) : {{AW{1'b0}}, 1'b1};
  assign wr_entry_s = {rx_error[FRAME_ERR], ~rx_success, rx_data};
  assign overrun_s  = push_s & ~wr_ok_s;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_s),
    .cap        (cap_s),
    .wr_en      (push_s),
    .wr_data    (wr_entry_s),
    .rd_en      (pop_s),
    .rd_data    (rd_entry_s),
    .empty      (empty_s),
    .full       (full_s),
    .level      (level_s),
    .level_next (level_next_s),
    .wr_ok      (wr_ok_s),
    .rd_ok      (rd_ok_s)
  );

  // Overrun flag and level interrupt next state.
  always_comb begin
    ovr_d       = ovr_q;
    irq_level_d = 1'b0;
    if (rx_thresh == {(AW+1){1'b0}}) begin
      thresh_s = {{AW{1'b0}}, 1'b1};
    end else begin
      thresh_s = rx_thresh;
    end
    // Setting has priority over ovr_clr; a clear cycle cannot overrun.
    if (clr_s) begin
      ovr_d = 1'b0;
    end else if (overrun_s) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    // Evaluated on the post-edge level so the irq moves together with level.
    if (fifo_en) begin
      irq_level_d = (level_next_s >= thresh_s);
    end else begin
      irq_level_d = (level_next_s != {(AW+1){1'b0}});
    end
  end

  // Mode tracking, overrun flag and level interrupt registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_en_q   <= 1'b1;
      ovr_q       <= 1'b0;
      irq_level_q <= 1'b0;
    end else begin
      fifo_en_q   <= fifo_en;
      ovr_q       <= ovr_d;
      irq_level_q <= irq_level_d;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [23:0] to_cnt_q, to_cnt_d;
  logic        irq_to_q, irq_to_d;

  // Idle counter and timeout interrupt next state.
  always_comb begin
    to_cnt_d = to_cnt_q;
    irq_to_d = irq_to_q;
    if (rx_done || rd_ok_s || clr_s || empty_s) begin
      to_cnt_d = 24'd0;
    end else begin
      to_cnt_d = to_cnt_q + 24'd1;
    end
    if (rx_done || rd_ok_s || clr_s) begin
      irq_to_d = 1'b0;
    end else if ((timeout_cycles != 24'd0) && (to_cnt_q == timeout_cycles)) begin
      irq_to_d = 1'b1;
    end else begin
      irq_to_d = irq_to_q;
    end
  end

  // Idle counter and timeout interrupt registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= 24'd0;
      irq_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      irq_to_q <= irq_to_d;
    end
  end

  assign irq_timeout = irq_to_q;
`endif

  assign rd_data      = rd_entry_s[DATA_W-1:0];
  assign rd_err       = rd_entry_s[EW-1:DATA_W];
  assign empty        = empty_s;
  assign level        = level_s;
  assign fifo_full    = full_s;
  assign rx_data_read = empty_s;
  assign irq_level    = irq_level_q;
  assign ovr_flag     = ovr_q;

endmodule
